// File: rtl/param_decoder.sv
// Registered binary-to-one-hot decoder: IN-bit digit -> 2**IN-bit vector, captured on en.
// Define DEC_ACTIVE_LOW_EN to make the output one-cold, with an all-ones reset value.
module param_decoder #(
    parameter int unsigned IN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [IN-1:0]        digit,
    output logic [(1<<IN)-1:0]   vector,
    output logic                 vld
);

    localparam int unsigned OUT = 1 << IN;

`ifdef DEC_ACTIVE_LOW_EN
    localparam logic [OUT-1:0] RST_VAL = '1;
`else
    localparam logic [OUT-1:0] RST_VAL = '0;
`endif

    logic [OUT-1:0] onehot;
    logic [OUT-1:0] vector_d, vector_q;
    logic           vld_d, vld_q;

    // Each output line compares against its own index, so the decode scales with IN.
    for (genvar gi = 0; gi < OUT; gi++) begin : g_dec
        assign onehot[gi] = (digit == IN'(gi));
    end

    always_comb begin
        vector_d = vector_q;
        vld_d    = en;
        if (en) begin
`ifdef DEC_ACTIVE_LOW_EN
            vector_d = ~onehot;
`else
            vector_d = onehot;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vector_q <= RST_VAL;
            vld_q    <= 1'b0;
        end else begin
            vector_q <= vector_d;
            vld_q    <= vld_d;
        end
    end

    assign vector = vector_q;
    assign vld    = vld_q;

endmodule

// File: tb/tb_param_decoder.sv
// Directed bench for param_decoder: IN=4 main instance plus an IN=1 width-corner instance.
module tb_param_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  digit;
    logic [15:0] vector;
    logic        vld;
    logic        en1;
    logic [0:0]  digit1;
    logic [1:0]  vector1;
    logic        vld1;

    int checks = 0;
    int errors = 0;

    param_decoder #(.IN(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .digit(digit), .vector(vector), .vld(vld)
    );

    param_decoder #(.IN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .digit(digit1), .vector(vector1), .vld(vld1)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pol(input logic [15:0] x);
`ifdef DEC_ACTIVE_LOW_EN
        return ~x;
`else
        return x;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] exp;
        logic [15:0] p1;
        logic [1:0]  exp2;

        rst_n  = 1'b0;
        en     = 1'b1;
        digit  = 4'd5;
        en1    = 1'b1;
        digit1 = 1'b1;

        // Reset held two cycles with en=1: capture must be suppressed
        for (int c = 0; c < 2; c++) begin
            tick();
            check("reset_vector", vector, pol(16'h0000));
            check("reset_vld", {15'd0, vld}, 16'd0);
            p1 = pol(16'h0000);
            exp2 = p1[1:0];
            check("reset_vector_in1", {14'd0, vector1}, {14'd0, exp2});
            check("reset_vld_in1", {15'd0, vld1}, 16'd0);
        end

        // Sweep every index back to back
        en1   = 1'b0;
        rst_n = 1'b1;
        exp   = 16'h0001;
        for (int i = 0; i < 16; i++) begin
            digit = 4'(i);
            tick();
            check($sformatf("sweep_vector_%0d", i), vector, pol(exp));
            check($sformatf("sweep_vld_%0d", i), {15'd0, vld}, 16'd1);
            check($sformatf("sweep_onehot_%0d", i), 16'($countones(pol(vector))), 16'd1);
            exp = exp << 1;
        end

        // Capture 9, then idle with digit toggling (including X)
        digit = 4'd9;
        tick();
        check("hold_capture", vector, pol(16'h0200));
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            digit = (c == 1) ? 4'bxxxx : 4'(c * 5 + 2);
            tick();
            check($sformatf("hold_vector_%0d", c), vector, pol(16'h0200));
            check($sformatf("hold_vld_%0d", c), {15'd0, vld}, 16'd0);
        end

        // Reset coincident with a capture wins
        en    = 1'b1;
        digit = 4'd3;
        rst_n = 1'b0;
        tick();
        check("midrst_vector", vector, pol(16'h0000));
        check("midrst_vld", {15'd0, vld}, 16'd0);
        rst_n = 1'b1;
        tick();
        check("postrst_vector", vector, pol(16'h0008));
        check("postrst_vld", {15'd0, vld}, 16'd1);

        // IN=1 width corner
        en     = 1'b0;
        en1    = 1'b1;
        digit1 = 1'b0;
        tick();
        p1 = pol(16'h0001);
        exp2 = p1[1:0];
        check("in1_digit0", {14'd0, vector1}, {14'd0, exp2});
        check("in1_vld", {15'd0, vld1}, 16'd1);
        digit1 = 1'b1;
        tick();
        p1 = pol(16'h0002);
        exp2 = p1[1:0];
        check("in1_digit1", {14'd0, vector1}, {14'd0, exp2});
        check("in4_idle_vld", {15'd0, vld}, 16'd0);
        check("in4_idle_vector", vector, pol(16'h0008));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
